// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life generation stepper.
// Holds the FSM state encoding, the board index helper and the neighbour-count width.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } life_state_t;

  localparam int NEIGH_W = 4;

  // Flat board index of cell (r,c); bit r*cols+c holds that cell.
  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Conway rule for one cell: alive next iff 3 neighbours, or alive with 2.
// Purely combinational; the neighbour count is a 4-bit popcount (max 8).
module life_cell_rule
  import life_pkg::*;
(
  input  logic       alive,
  input  logic [7:0] neighbours,
  output logic       next_alive
);

  logic [NEIGH_W-1:0] count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + NEIGH_W'(neighbours[i]);
    end
    next_alive = (count == NEIGH_W'(3)) || (alive && (count == NEIGH_W'(2)));
  end

endmodule

// File: rtl/life_generation_stepper.sv
// Advances a toroidal Life board one generation per accepted step: one row per clock into a
// shadow buffer, then a single-cycle commit; steps arriving while busy are dropped and flagged.
module life_generation_stepper
  import life_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 step,
  input  logic                 run_en,
  input  logic                 load_valid,
  input  logic [ROWS*COLS-1:0] load_data,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     generation,
  output logic                 busy,
  output logic                 gen_done,
  output logic                 missed_step
);

  localparam int N     = ROWS * COLS;
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  life_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [N-1:0]     cells_q, cells_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             gen_done_q, gen_done_d;
  logic             missed_q, missed_d;

  logic [ROW_W-1:0] row_up, row_dn;
  logic [COLS-1:0]  up_row, mid_row, dn_row, next_row;

  // Neighbour rows always come from the committed board, with vertical wrap.
  always_comb begin
    row_up  = (row_q == '0) ? LAST_ROW : row_q - ROW_W'(1);
    row_dn  = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
    up_row  = cells_q[cell_idx(int'(row_up), 0, COLS) +: COLS];
    mid_row = cells_q[cell_idx(int'(row_q), 0, COLS) +: COLS];
    dn_row  = cells_q[cell_idx(int'(row_dn), 0, COLS) +: COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL = (c == 0) ? COLS - 1 : c - 1;
    localparam int CR = (c == COLS - 1) ? 0 : c + 1;

    life_cell_rule u_rule (
      .alive      (mid_row[c]),
      .neighbours ({up_row[CL], up_row[c], up_row[CR],
                    mid_row[CL],            mid_row[CR],
                    dn_row[CL], dn_row[c], dn_row[CR]}),
      .next_alive (next_row[c])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cells_d    = cells_q;
    shadow_d   = shadow_q;
    gen_d      = gen_q;
    gen_done_d = 1'b0;
    missed_d   = missed_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          cells_d  = load_data;
          gen_d    = '0;
          missed_d = 1'b0;
        end else if (step && run_en) begin
          row_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        shadow_d[cell_idx(int'(row_q), 0, COLS) +: COLS] = next_row;
        if (step) missed_d = 1'b1;
        if (row_q == LAST_ROW) state_d = COMMIT;
        else                   row_d   = row_q + ROW_W'(1);
      end
      COMMIT: begin
        cells_d    = shadow_q;
        gen_d      = gen_q + GEN_W'(1);
        gen_done_d = 1'b1;
        if (step) missed_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cells_q    <= '0;
      shadow_q   <= '0;
      gen_q      <= '0;
      gen_done_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cells_q    <= cells_d;
      shadow_q   <= shadow_d;
      gen_q      <= gen_d;
      gen_done_q <= gen_done_d;
      missed_q   <= missed_d;
    end
  end

  assign cells       = cells_q;
  assign generation  = gen_q;
  assign busy        = (state_q != IDLE);
  assign gen_done    = gen_done_q;
  assign missed_step = missed_q;

endmodule

// File: tb/tb_life_generation_stepper.sv
// Bench for life_generation_stepper: a reference Life model feeds a scoreboard checked on
// every gen_done, a table of load/step vectors, and hand sequences for the multi-cycle corners.
module tb_life_generation_stepper;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;
  localparam int N     = ROWS * COLS;
  localparam int NV    = 5;

  typedef logic [N-1:0] board_t;

  typedef struct {
    board_t           cells;
    logic [GEN_W-1:0] gen;
  } exp_t;

  typedef struct {
    board_t load;
    int     nsteps;
    board_t exp_cells;
    int     exp_gen;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             step;
  logic             run_en;
  logic             load_valid;
  board_t           load_data;
  board_t           cells;
  logic [GEN_W-1:0] generation;
  logic             busy;
  logic             gen_done;
  logic             missed_step;

  int               n_checks = 0;
  int               n_fail   = 0;
  exp_t             sb_q[$];
  board_t           model_b;
  logic [GEN_W-1:0] model_g;

  always #5 clk = ~clk;

  life_generation_stepper #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .GEN_W (GEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .run_en      (run_en),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .cells       (cells),
    .generation  (generation),
    .busy        (busy),
    .gen_done    (gen_done),
    .missed_step (missed_step)
  );

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: explicit modular wrap over all eight offsets.
  function automatic board_t life_next(input board_t b);
    board_t nb;
    int     n;
    nb = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              n += int'(b[((r + dr + ROWS) % ROWS) * COLS + ((c + dc + COLS) % COLS)]);
          end
        end
        nb[r * COLS + c] = (n == 3) || (b[r * COLS + c] && n == 2);
      end
    end
    return nb;
  endfunction

  // Scoreboard consumer: every gen_done must match the oldest expected generation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (gen_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("gen_done_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_cells", cells, e.cells);
          check("sb_generation", generation, e.gen);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input board_t p);
    load_valid = 1'b1;
    load_data  = p;
    tick();
    load_valid = 1'b0;
    model_b    = p;
    model_g    = '0;
  endtask

  task automatic push_expected();
    model_b = life_next(model_b);
    model_g = model_g + GEN_W'(1);
    sb_q.push_back('{model_b, model_g});
  endtask

  task automatic wait_gen_done(input string name, input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      step = 1'b0;
    end while (gen_done !== 1'b1 && lat < budget);
    check(name, gen_done, 1);
  endtask

  task automatic step_and_wait(output int lat);
    step = 1'b1;
    push_expected();
    lat = 0;
    do begin
      tick();
      lat++;
      step = 1'b0;
      if (lat == 1) check("busy_after_step", busy, 1);
    end while (gen_done !== 1'b1 && lat < 40);
    check("gen_done_seen", gen_done, 1);
  endtask

  board_t blinker_h, blinker_v, block_c, glider;
  vec_t   vecs[NV];
  int     lat;

  initial begin
    blinker_h = '0; blinker_h[26] = 1'b1; blinker_h[27] = 1'b1; blinker_h[28] = 1'b1;
    blinker_v = '0; blinker_v[19] = 1'b1; blinker_v[27] = 1'b1; blinker_v[35] = 1'b1;
    block_c   = '0; block_c[0] = 1'b1; block_c[7] = 1'b1; block_c[56] = 1'b1; block_c[63] = 1'b1;
    glider    = '0; glider[1] = 1'b1; glider[10] = 1'b1; glider[16] = 1'b1;
    glider[17] = 1'b1; glider[18] = 1'b1;

    vecs[0] = '{blinker_h, 1,  blinker_v, 1};
    vecs[1] = '{blinker_h, 2,  blinker_h, 2};
    vecs[2] = '{block_c,   5,  block_c,   5};
    vecs[3] = '{glider,    32, glider,    32};
    vecs[4] = '{'0,        3,  '0,        3};

    rst = 1'b0; step = 1'b0; run_en = 1'b1; load_valid = 1'b0; load_data = '0;
    model_b = '0; model_g = '0;
    #2;
    check("rst_cells", cells, 0);
    check("rst_generation", generation, 0);
    check("rst_busy", busy, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_missed", missed_step, 0);
    tick();
    rst = 1'b1;
    tick();

    // Table vectors; back-to-back steps land in the gen_done cycle.
    for (int i = 0; i < NV; i++) begin
      do_load(vecs[i].load);
      check($sformatf("load_cells[%0d]", i), cells, vecs[i].load);
      check($sformatf("load_gen[%0d]", i), generation, 0);
      for (int s = 0; s < vecs[i].nsteps; s++) begin
        step_and_wait(lat);
        check($sformatf("latency[%0d.%0d]", i, s), lat, ROWS + 2);
      end
      check($sformatf("final_cells[%0d]", i), cells, vecs[i].exp_cells);
      check($sformatf("final_gen[%0d]", i), generation, vecs[i].exp_gen);
    end
    check("no_missed_back_to_back", missed_step, 0);

    // Overrun: second step three cycles later is dropped and flagged.
    do_load(blinker_h);
    step = 1'b1;
    push_expected();
    tick();
    step = 1'b0;
    tick();
    tick();
    step = 1'b1;
    wait_gen_done("overrun_gen_done", 40, lat);
    check("overrun_missed", missed_step, 1);
    check("overrun_generation", generation, 1);
    repeat (15) tick();
    check("overrun_idle", busy, 0);

    // Paused: step ignored, flag untouched; a load clears the flag.
    run_en = 1'b0;
    step   = 1'b1;
    tick();
    step   = 1'b0;
    check("pause_busy0", busy, 0);
    repeat (12) tick();
    check("pause_busy1", busy, 0);
    check("pause_generation", generation, 1);
    check("pause_missed_kept", missed_step, 1);
    run_en = 1'b1;
    do_load(blinker_h);
    check("load_clears_missed", missed_step, 0);

    // run_en dropped and load attempted mid-compute: generation still completes.
    step = 1'b1;
    push_expected();
    tick();
    step       = 1'b0;
    run_en     = 1'b0;
    load_valid = 1'b1;
    load_data  = glider;
    tick();
    load_valid = 1'b0;
    wait_gen_done("midrun_gen_done", 40, lat);
    check("midrun_cells", cells, blinker_v);
    check("midrun_generation", generation, 1);
    run_en = 1'b1;

    // Load beats step in the same IDLE cycle.
    tick();
    step       = 1'b1;
    load_valid = 1'b1;
    load_data  = '0;
    tick();
    step       = 1'b0;
    load_valid = 1'b0;
    model_b    = '0;
    model_g    = '0;
    check("prio_busy0", busy, 0);
    tick();
    check("prio_busy1", busy, 0);
    check("prio_cells", cells, 0);
    check("prio_generation", generation, 0);

    // Async reset four cycles into COMPUTE, with the overrun flag set.
    do_load(glider);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_missed", missed_step, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cells", cells, 0);
    check("arst_generation", generation, 0);
    check("arst_gen_done", gen_done, 0);
    check("arst_missed", missed_step, 0);
    sb_q.delete();
    #1;
    rst = 1'b1;
    repeat (20) tick();
    check("post_reset_busy", busy, 0);
    check("post_reset_generation", generation, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/life_generation_stepper.md
Name: life_generation_stepper

Overview:
- Downstream consumer of the 1-second tick timer in the life circuit.
- Each accepted `step` pulse advances a toroidal Conway Game of Life board by exactly one generation.
- Computes one row per clock into a shadow buffer, then commits atomically, so display logic never sees a half-updated board.
- Also handles pattern loading, run/pause gating, a generation counter and overrun detection.

Parameters:
- ROWS, 8, board height in cells (>=3).
- COLS, 8, board width in cells (>=3).
- GEN_W, 16, generation counter width.

Ports:
- clk  input  1  system clock (12 MHz).
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- step  input  1  one-cycle advance request (timer output pulse).
- run_en  input  1  1 = accept steps; 0 = paused, steps ignored.
- load_valid  input  1  request to overwrite board with load_data.
- load_data  input  ROWS*COLS  new board; bit r*COLS+c = cell (r,c), 1 = alive.
- cells  output  ROWS*COLS  committed board, same bit mapping.
- generation  output  GEN_W  generations since last load/reset.
- busy  output  1  high while in COMPUTE or COMMIT.
- gen_done  output  1  one-cycle pulse after each commit.
- missed_step  output  1  sticky flag: a step arrived while busy.

Behaviour:
- Reset (rst=0, async): state=IDLE, cells=0, generation=0, busy=0, gen_done=0, missed_step=0, row index=0, shadow buffer=0. Any in-progress generation is abandoned.
- State machine `life_state_t`:
  - IDLE: load_valid has priority. If load_valid=1: cells<=load_data, generation<=0, missed_step<=0, stay IDLE. Else if step=1 and run_en=1: row<=0, go COMPUTE. Otherwise hold.
  - COMPUTE: each cycle writes next-generation row `row` into the shadow buffer from the committed cells. If row==ROWS-1, go COMMIT; else row<=row+1.
  - COMMIT (one cycle): cells<=shadow, generation<=generation+1, gen_done<=1 (registered, high for the cycle after COMMIT), go IDLE.
- Latency: step sampled at edge t. COMPUTE occupies edges t+1..t+ROWS. cells/generation update at edge t+ROWS+1, and gen_done is high during the following cycle. busy=1 from edge t+1 through edge t+ROWS+1.
- Rules:
  - A cell is alive next generation iff it has 3 live neighbours, or it is alive and has 2 live neighbours.
  - The 8 neighbours are taken from the 8-connected ring, toroidal: row -1 wraps to ROWS-1, col COLS wraps to 0.
  - The neighbour count is 4 bits unsigned (max 8).
- The shadow buffer reads only committed cells, so no row's result depends on another row of the new generation.
- Boundary conditions:
  - step while busy: dropped and missed_step<=1. The current generation completes unaffected.
  - load_valid while busy: ignored; no queueing.
  - step with run_en=0: ignored, no flag.
  - run_en deasserted mid-compute: the current generation still completes.
  - step and load_valid together in IDLE: load wins and the step is discarded.
  - generation wraps from 2^GEN_W-1 to 0 silently.
  - gen_done and a new step in the same cycle: the step is accepted (state is IDLE).

Decomposition:
- life_pkg:
  - `life_state_t` enum {IDLE, COMPUTE, COMMIT}.
  - Function `cell_idx(r,c)` returning r*COLS+c.
  - Localparam NEIGH_W=4.
- Sub-module `life_cell_rule` (combinational): inputs alive(1), neighbours(8); output next_alive(1), using a 4-bit popcount.
  - The stepper instantiates COLS copies for the active row.
  - Row/column wrap muxing lives in the stepper.

Test Plan:
- Blinker: load 8x8 with cells (3,2),(3,3),(3,4) alive; run_en=1; pulse step. Expect gen_done 10 cycles after step. Expect cells = (2,3),(3,3),(4,3) and generation=1. A second step restores the original pattern, generation=2.
- Still life and wrap: load a 2x2 block straddling the corner at (7,7),(7,0),(0,7),(0,0); apply 5 steps. Expect cells unchanged after each gen_done and generation=5, proving toroidal wrap.
- Glider: load a glider on 8x8 and apply 32 steps, waiting for gen_done each time. Expect cells equal the loaded pattern and generation=32.
- Overrun/pause:
  - Step at t, second step at t+3: one gen_done only, missed_step=1, generation=1.
  - With run_en=0, a step gives no busy and generation unchanged.
  - A subsequent load clears missed_step.
- Priority: step and load_valid (all-zero pattern) in the same IDLE cycle. Expect busy stays 0, cells=0, generation=0.
- Reset mid-operation: assert rst=0 asynchronously 4 cycles into COMPUTE. Expect busy, cells, generation, gen_done and missed_step all 0 immediately. After release, no gen_done appears.
